qrisc32_mem_stage: RTL and testbench

Memory-access stage of the Qrisc32 pipeline, sitting directly downstream of the execute stage. It consumes the execute-stage `pipe_struct` output, performs data-memory loads and stores over a simple request/acknowledge bus, and back-pressures the earlier stages through `pipe_stall` while an access is outstanding. It also registers the execute stage's branch target (`new_address_valid`/`new_address`) and forwards it to fetch.

---
 rtl/qrisc32_mem_stage.sv | 190 +++++++++++++++++++
 tb/tb_qrisc32_mem_stage.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/qrisc32_mem_stage.sv
// qrisc32_mem_stage
//   Memory-access stage of the Qrisc32 pipeline. It takes the execute-stage
//   result and performs data-memory loads and stores over a request/ack bus.
//   While an access is outstanding it holds the upstream stages with
//   pipe_stall and sends bubbles to write-back. It also registers the
//   execute-stage branch target for fetch on every cycle.
//
// Optional build macro:
//   QRISC32_MEM_ALIGN_CHECK_EN - when defined, a memory op whose address has
//   val_r1[1:0] != 0 is completed locally and flagged with bus_error, without
//   a bus access. When undefined, addresses go to the bus unchecked.
//
// Ports:
//   clk                 single clock, all state on the rising edge
//   reset               asynchronous reset, active low
//   pipe_mem_in         execute result (val_r1 = address, val_dst = store data)
//   new_address_valid   branch-taken strobe from execute
//   new_address         branch target from execute
//   pipe_mem_out        result to write-back (loads return data in val_dst)
//   pipe_stall          combinational hold for fetch/decode/execute
//   jump_valid          registered new_address_valid
//   jump_address        registered new_address
//   dmem_addr           data bus address
//   dmem_rd / dmem_wr   read / write strobes, held until ack or timeout
//   dmem_wdata          store data
//   dmem_rdata          load data, valid together with dmem_ack
//   dmem_ack            access complete
//   bus_error           one-cycle pulse on timeout or misaligned access
//
// FSM states:
//   state    | meaning
//   S_IDLE   | no access outstanding; non-memory ops pass in one cycle
//   S_ACCESS | strobe on the bus, waiting for dmem_ack or the timeout

package qrisc32_pkg;
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] ir;
      logic [31:0] val_r1;
      logic [31:0] val_r2;
      logic [31:0] val_dst;
      logic [4:0]  dst_r;
      logic        write_reg;
      logic        read_mem;
      logic        write_mem;
   } pipe_struct;
endpackage

module qrisc32_mem_stage
   import qrisc32_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  pipe_struct  pipe_mem_in,
   input  logic        new_address_valid,
   input  logic [31:0] new_address,
   output pipe_struct  pipe_mem_out,
   output logic        pipe_stall,
   output logic        jump_valid,
   output logic [31:0] jump_address,
   output logic [31:0] dmem_addr,
   output logic        dmem_rd,
   output logic        dmem_wr,
   output logic [31:0] dmem_wdata,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_ack,
   output logic        bus_error
);

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

   typedef enum logic {S_IDLE, S_ACCESS} state_t;

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   pipe_struct  out_q, out_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        rd_q, rd_d;
   logic        wr_q, wr_d;
   logic        berr_q, berr_d;
   logic        jv_q;
   logic [31:0] ja_q;
   logic        stall;

   logic mem_op;
   logic misalign;

   assign mem_op = pipe_mem_in.read_mem | pipe_mem_in.write_mem;

`ifdef QRISC32_MEM_ALIGN_CHECK_EN
   assign misalign = |pipe_mem_in.val_r1[1:0];
`else
   assign misalign = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      out_d   = out_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      berr_d  = 1'b0;
      stall   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (mem_op && misalign) begin
               // Rejected locally: completes this cycle, no bus traffic.
               out_d = pipe_mem_in;
               if (pipe_mem_in.read_mem) out_d.val_dst = '0;
               berr_d = 1'b1;
            end else if (mem_op) begin
               stall   = 1'b1;
               addr_d  = pipe_mem_in.val_r1;
               wdata_d = pipe_mem_in.val_dst;
               rd_d    = pipe_mem_in.read_mem;
               // A read takes precedence when both flags are set.
               wr_d    = pipe_mem_in.write_mem & ~pipe_mem_in.read_mem;
               out_d   = '0;
               cnt_d   = '0;
               state_d = S_ACCESS;
            end else begin
               out_d = pipe_mem_in;
            end
         end

         S_ACCESS: begin
            if (dmem_ack || (cnt_q == CNT_LAST)) begin
               // Timeout is handled as a completion that returns zero data.
               out_d = pipe_mem_in;
               if (rd_q) out_d.val_dst = dmem_ack ? dmem_rdata : 32'h0;
               berr_d  = ~dmem_ack;
               rd_d    = 1'b0;
               wr_d    = 1'b0;
               cnt_d   = '0;
               state_d = S_IDLE;
            end else begin
               stall = 1'b1;
               cnt_d = cnt_q + 8'd1;
               out_d = '0;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         out_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         berr_q  <= 1'b0;
         jv_q    <= 1'b0;
         ja_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         out_q   <= out_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         berr_q  <= berr_d;
         // Branch target is captured regardless of stall so it is never lost.
         jv_q    <= new_address_valid;
         ja_q    <= new_address;
      end
   end

   assign pipe_mem_out = out_q;
   assign pipe_stall   = stall;
   assign jump_valid   = jv_q;
   assign jump_address = ja_q;
   assign dmem_addr    = addr_q;
   assign dmem_rd      = rd_q;
   assign dmem_wr      = wr_q;
   assign dmem_wdata   = wdata_q;
   assign bus_error    = berr_q;

endmodule

// File: tb/tb_qrisc32_mem_stage.sv
module tb_qrisc32_mem_stage;
   import qrisc32_pkg::*;

   localparam int W = $bits(pipe_struct);

   logic        clk = 1'b0;
   logic        reset;
   pipe_struct  pin;
   logic        nav;
   logic [31:0] na;
   pipe_struct  pout;
   logic        stall;
   logic        jv;
   logic [31:0] ja;
   logic [31:0] addr;
   logic        rd;
   logic        wr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        ack;
   logic        berr;

   int checks = 0;
   int failures = 0;

   qrisc32_mem_stage #(.TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .reset(reset), .pipe_mem_in(pin),
      .new_address_valid(nav), .new_address(na),
      .pipe_mem_out(pout), .pipe_stall(stall),
      .jump_valid(jv), .jump_address(ja),
      .dmem_addr(addr), .dmem_rd(rd), .dmem_wr(wr), .dmem_wdata(wdata),
      .dmem_rdata(rdata), .dmem_ack(ack), .bus_error(berr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_p(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic pipe_struct mk(input logic [31:0] pc, input logic [31:0] r1,
                                     input logic [31:0] dst, input logic rdm, input logic wrm);
      pipe_struct p;
      p = '0;
      p.pc        = pc;
      p.ir        = pc ^ 32'hA5A5_0000;
      p.val_r1    = r1;
      p.val_r2    = 32'h0000_0777;
      p.val_dst   = dst;
      p.dst_r     = 5'd3;
      p.write_reg = 1'b1;
      p.read_mem  = rdm;
      p.write_mem = wrm;
      return p;
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      pipe_struct p1, p2, p3, p4, p5, p6, exp;
      int stalls, wrcyc, acc, stl;

      p1 = mk(32'h10, 32'h0,   32'h0000_1234, 1'b0, 1'b0);
      p2 = mk(32'h14, 32'h100, 32'h0,         1'b1, 1'b0);
      p3 = mk(32'h18, 32'h204, 32'h0000_55AA, 1'b0, 1'b1);
      p4 = mk(32'h1C, 32'h300, 32'hDEAD_0000, 1'b1, 1'b0);
      p5 = mk(32'h20, 32'h400, 32'h0000_0077, 1'b1, 1'b1);
      p6 = mk(32'h24, 32'h103, 32'h0000_0099, 1'b1, 1'b0);

      reset = 1'b0; pin = '0; nav = 1'b0; na = '0; rdata = '0; ack = 1'b0;
      #3;
      chk_p("rst_out", pout, '0);
      chk("rst_rd", 32'(rd), 32'd0);
      chk("rst_wr", 32'(wr), 32'd0);
      chk("rst_berr", 32'(berr), 32'd0);
      chk("rst_jv", 32'(jv), 32'd0);
      chk("rst_addr", addr, 32'h0);
      chk("rst_stall_noop", 32'(stall), 32'd0);
      pin = p2;
      #1 chk("rst_stall_memop", 32'(stall), 32'd1);
      pin = '0;
      tick;
      reset = 1'b1;

      // Non-memory op passes in one cycle, no stall.
      pin = p1;
      #1 chk("nop_stall", 32'(stall), 32'd0);
      tick;
      chk_p("nop_out", pout, p1);

      // Load acked in the first ACCESS cycle.
      pin = p2;
      #1 chk("ld_stall_idle", 32'(stall), 32'd1);
      tick;
      chk("ld_rd", 32'(rd), 32'd1);
      chk("ld_wr", 32'(wr), 32'd0);
      chk("ld_addr", addr, 32'h100);
      chk_p("ld_bubble", pout, '0);
      ack = 1'b1; rdata = 32'hCAFE_0001;
      #1 chk("ld_stall_ack", 32'(stall), 32'd0);
      tick;
      ack = 1'b0; pin = p1;
      exp = p2; exp.val_dst = 32'hCAFE_0001;
      chk_p("ld_out", pout, exp);
      chk("ld_rd_drop", 32'(rd), 32'd0);
      chk("ld_berr", 32'(berr), 32'd0);
      tick;

      // Store acked after three wait cycles.
      pin = p3; stalls = 0; wrcyc = 0;
      #1 if (stall) stalls++;
      tick;
      for (int k = 0; k < 4; k++) begin
         if (k == 3) ack = 1'b1;
         #1;
         if (wr) wrcyc++;
         if (stall) stalls++;
         chk("st_addr", addr, 32'h204);
         chk("st_wdata", wdata, 32'h0000_55AA);
         chk_p("st_bubble", pout, '0);
         tick;
      end
      ack = 1'b0;
      chk("st_stalls", 32'(stalls), 32'd4);
      chk("st_wr_cycles", 32'(wrcyc), 32'd4);
      chk_p("st_out", pout, p3);
      chk("st_wr_drop", 32'(wr), 32'd0);
      pin = p1;
      tick;
      chk_p("st_single_out", pout, p1);

      // Load with no ack: timeout, plus a branch during the stall.
      pin = p4; rdata = 32'h1234_5678;
      tick;
      acc = 0; stl = 0;
      for (int k = 0; k < 20 && rd; k++) begin
         acc++;
         if (stall) stl++;
         if (berr) chk("to_berr_early", 32'(berr), 32'd0);
         if (k == 0) begin nav = 1'b1; na = 32'h40; end
         tick;
         if (k == 0) begin
            chk("jmp_valid", 32'(jv), 32'd1);
            chk("jmp_addr", ja, 32'h40);
            nav = 1'b0; na = 32'h0;
         end
      end
      chk("to_access_cycles", 32'(acc), 32'd16);
      chk("to_stalls", 32'(stl), 32'd15);
      chk("to_berr", 32'(berr), 32'd1);
      chk("jmp_clear", 32'(jv), 32'd0);
      exp = p4; exp.val_dst = 32'h0;
      chk_p("to_out", pout, exp);
      pin = p1;
      tick;
      chk("to_berr_pulse", 32'(berr), 32'd0);
      chk_p("to_idle_out", pout, p1);

      // Read and write both set: read wins.
      pin = p5;
      tick;
      chk("rw_rd", 32'(rd), 32'd1);
      chk("rw_wr", 32'(wr), 32'd0);
      ack = 1'b1; rdata = 32'h0000_BEEF;
      tick;
      ack = 1'b0; pin = p1;
      exp = p5; exp.val_dst = 32'h0000_BEEF;
      chk_p("rw_out", pout, exp);

      // Ack while idle is ignored.
      ack = 1'b1; rdata = 32'hFFFF_FFFF;
      #1 chk("idle_ack_stall", 32'(stall), 32'd0);
      tick;
      ack = 1'b0;
      chk_p("idle_ack_out", pout, p1);
      chk("idle_ack_rd", 32'(rd), 32'd0);

      // Back-to-back loads: strobe drops for a cycle between accesses.
      pin = p2;
      tick;
      ack = 1'b1; rdata = 32'h1;
      tick;
      ack = 1'b0;
      chk("b2b_gap_rd", 32'(rd), 32'd0);
      chk("b2b_gap_stall", 32'(stall), 32'd1);
      tick;
      chk("b2b_second_rd", 32'(rd), 32'd1);
      ack = 1'b1; rdata = 32'h2;
      tick;
      ack = 1'b0; pin = p1;
      exp = p2; exp.val_dst = 32'h2;
      chk_p("b2b_out", pout, exp);
      tick;

      // Reset in the middle of an access.
      pin = p4; nav = 1'b1; na = 32'h80;
      tick;
      chk("mr_rd_before", 32'(rd), 32'd1);
      chk("mr_jv_before", 32'(jv), 32'd1);
      #2 reset = 1'b0;
      #1;
      chk("mr_rd", 32'(rd), 32'd0);
      chk("mr_wr", 32'(wr), 32'd0);
      chk("mr_berr", 32'(berr), 32'd0);
      chk("mr_jv", 32'(jv), 32'd0);
      chk("mr_ja", ja, 32'h0);
      chk("mr_addr", addr, 32'h0);
      chk_p("mr_out", pout, '0);
      chk("mr_stall_memop", 32'(stall), 32'd1);
      pin = p1; nav = 1'b0; na = '0;
      tick;
      reset = 1'b1;
      tick;
      chk_p("mr_idle_out", pout, p1);
      chk("mr_idle_rd", 32'(rd), 32'd0);
      pin = p2;
      tick;
      chk("mr_new_access", 32'(rd), 32'd1);
      ack = 1'b1; rdata = 32'h3;
      tick;
      ack = 1'b0; pin = p1;
      tick;

      // Misaligned load.
      pin = p6;
`ifdef QRISC32_MEM_ALIGN_CHECK_EN
      #1 chk("mis_stall", 32'(stall), 32'd0);
      tick;
      chk("mis_rd", 32'(rd), 32'd0);
      chk("mis_berr", 32'(berr), 32'd1);
      exp = p6; exp.val_dst = 32'h0;
      chk_p("mis_out", pout, exp);
      pin = p1;
      tick;
      chk("mis_berr_pulse", 32'(berr), 32'd0);
`else
      #1 chk("mis_stall", 32'(stall), 32'd1);
      tick;
      chk("mis_rd", 32'(rd), 32'd1);
      chk("mis_addr", addr, 32'h103);
      ack = 1'b1; rdata = 32'h5;
      tick;
      ack = 1'b0; pin = p1;
      exp = p6; exp.val_dst = 32'h5;
      chk_p("mis_out", pout, exp);
      chk("mis_berr", 32'(berr), 32'd0);
      tick;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
